tnn_cmp_sweep: RTL and testbench

- Sequential exhaustive driver/checker for the team's 3-input threshold comparator units. These are the CGP-evolved blocks with ports input_a, input_b, input_c and a 1-bit cgp_out.
- It drives every {c,b,a} operand combination into the comparator under test and samples the comparator's decision bit.
- It compares each sample against the exact function out = (a + b) >= c and counts false positives and false negatives.
- Used on-chip and in FPGA characterization to measure the error of library entries in hardware.

---
 rtl/tnn_cmp_sweep.sv | 138 +++++++++++++
 tb/tb_tnn_cmp_sweep.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tnn_cmp_sweep.sv
// tnn_cmp_sweep: exhaustive {c,b,a} sweep of a 3-input threshold comparator with error counting
module tnn_cmp_sweep #(
    parameter int W   = 3,
    parameter int LAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [W-1:0]   dut_a,
    output logic [W-1:0]   dut_b,
    output logic [W-1:0]   dut_c,
    input  logic           dut_out,
    output logic           busy,
    output logic           done,
    output logic [3*W:0]   fp_count,
    output logic [3*W:0]   fn_count,
    output logic [3*W:0]   err_count,
    output logic           first_err_valid,
    output logic [3*W-1:0] first_err_vec
);
    localparam int N  = 3 * W;
    localparam int DW = $clog2(LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [N:0]    fp_q, fp_d, fn_q, fn_d;
    logic          fv_q, fv_d;
    logic [N-1:0]  fev_q, fev_d;
    logic [W:0]    sum;
    logic          exp_now, chk_valid, chk_exp;
    logic [N-1:0]  chk_vec;

    assign dut_a           = vec_q[W-1:0];
    assign dut_b           = vec_q[2*W-1:W];
    assign dut_c           = vec_q[N-1:2*W];
    assign sum             = {1'b0, dut_a} + {1'b0, dut_b};
    assign exp_now         = sum >= {1'b0, dut_c};
    assign busy            = state_q == RUN || state_q == DRAIN;
    assign done            = state_q == DONE;
    assign fp_count        = fp_q;
    assign fn_count        = fn_q;
    assign err_count       = fp_q + fn_q;
    assign first_err_valid = fv_q;
    assign first_err_vec   = fev_q;

    generate
        if (LAT == 0) begin : g_comb
            assign chk_valid = state_q == RUN;
            assign chk_exp   = exp_now;
            assign chk_vec   = vec_q;
        end else begin : g_pipe
            logic [LAT-1:0]   pv_q, pv_d, pe_q, pe_d;
            logic [LAT*N-1:0] pvec_q, pvec_d;
            // shift expected value, valid and vector alongside the comparator latency
            always_comb begin
                pv_d   = LAT'({pv_q, state_q == RUN});
                pe_d   = LAT'({pe_q, exp_now});
                pvec_d = (LAT*N)'({pvec_q, vec_q});
            end
            // pipeline registers, emptied on reset
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pv_q   <= '0;
                    pe_q   <= '0;
                    pvec_q <= '0;
                end else begin
                    pv_q   <= pv_d;
                    pe_q   <= pe_d;
                    pvec_q <= pvec_d;
                end
            end
            assign chk_valid = pv_q[LAT-1];
            assign chk_exp   = pe_q[LAT-1];
            assign chk_vec   = pvec_q[LAT*N-1 -: N];
        end
    endgenerate

    // sweep sequencing plus mismatch accounting at the pipeline tail
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        fp_d    = fp_q;
        fn_d    = fn_q;
        fv_d    = fv_q;
        fev_d   = fev_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                vec_d   = '0;
                fp_d    = '0;
                fn_d    = '0;
                fv_d    = 1'b0;
                fev_d   = '0;
            end
            RUN: begin
                drain_d = '0;
                if (&vec_q) state_d = (LAT == 0) ? DONE : DRAIN;
                else vec_d = vec_q + 1'b1;
            end
            DRAIN: if (drain_q == DW'(LAT - 1)) state_d = DONE;
                   else drain_d = drain_q + 1'b1;
            default: state_d = IDLE;
        endcase
        if (chk_valid && chk_exp != dut_out) begin
            fp_d = fp_q + (N+1)'(dut_out);
            fn_d = fn_q + (N+1)'(!dut_out);
            if (!fv_q) begin
                fv_d  = 1'b1;
                fev_d = chk_vec;
            end
        end
    end

    // state and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            drain_q <= '0;
            fp_q    <= '0;
            fn_q    <= '0;
            fv_q    <= 1'b0;
            fev_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            drain_q <= drain_d;
            fp_q    <= fp_d;
            fn_q    <= fn_d;
            fv_q    <= fv_d;
            fev_q   <= fev_d;
        end
    end
endmodule

// File: tb/tb_tnn_cmp_sweep.sv
// tb_tnn_cmp_sweep: directed checks of the sweep engine against comparator models with known error counts
module tb_tnn_cmp_sweep;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    int         mode = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic [2:0] a0, b0, c0, a2, b2, c2;
    logic       out0, out2, busy0, busy2, done0, done2, fv0, fv2;
    logic [9:0] fp0, fn0, err0, fp2, fn2, err2;
    logic [8:0] fev0, fev2;
    logic       ex0, ex2, p0a, p0b, p2a, p2b;

    tnn_cmp_sweep #(.W(3), .LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_out(out0),
        .busy(busy0), .done(done0),
        .fp_count(fp0), .fn_count(fn0), .err_count(err0),
        .first_err_valid(fv0), .first_err_vec(fev0)
    );

    tnn_cmp_sweep #(.W(3), .LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(a2), .dut_b(b2), .dut_c(c2), .dut_out(out2),
        .busy(busy2), .done(done2),
        .fp_count(fp2), .fn_count(fn2), .err_count(err2),
        .first_err_valid(fv2), .first_err_vec(fev2)
    );

    always #5 clk = ~clk;

    assign ex0 = ({1'b0, a0} + {1'b0, b0}) >= {1'b0, c0};
    assign ex2 = ({1'b0, a2} + {1'b0, b2}) >= {1'b0, c2};

    always_ff @(posedge clk) begin
        p0a <= ex0;
        p0b <= p0a;
        p2a <= ex2;
        p2b <= p2a;
    end

    assign out0 = mode == 0 ? ex0 : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : mode == 3 ? !ex0 : p0b;
    assign out2 = p2b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sweep(input int start_at, input int rst_at,
                         output int d0, output int d2, output int nd0, output int nd2,
                         output int bc0, output int bc2);
        d0 = -1; d2 = -1; nd0 = 0; nd2 = 0; bc0 = 0; bc2 = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 600; j++) begin
            if (busy0) bc0++;
            if (busy2) bc2++;
            if (done0) begin nd0++; d0 = j; end
            if (done2) begin nd2++; d2 = j; end
            start = (j == start_at);
            rst_n = !(j == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    int d0, d2, nd0, nd2, bc0, bc2;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_fvalid", fv0, 0);
        check("rst_vec", {c0, b0, a0}, 0);
        check("rst_busy_lat2", busy2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0;
        sweep(-1, -1, d0, d2, nd0, nd2, bc0, bc2);
        check("exact_done_at", d0, 512);
        check("exact_ndone", nd0, 1);
        check("exact_busy", bc0, 512);
        check("exact_err", err0, 0);
        check("exact_fp", fp0, 0);
        check("exact_fn", fn0, 0);
        check("exact_fvalid", fv0, 0);
        check("hold_vec", {c0, b0, a0}, 511);
        check("lat2_done_at", d2, 514);
        check("lat2_busy", bc2, 514);
        check("lat2_err", err2, 0);
        check("lat2_fvalid", fv2, 0);

        mode = 1;
        sweep(-1, -1, d0, d2, nd0, nd2, bc0, bc2);
        check("tie0_err", err0, 428);
        check("tie0_fn", fn0, 428);
        check("tie0_fp", fp0, 0);
        check("tie0_fvalid", fv0, 1);
        check("tie0_fvec", fev0, 0);

        mode = 2;
        sweep(-1, -1, d0, d2, nd0, nd2, bc0, bc2);
        check("tie1_err", err0, 84);
        check("tie1_fp", fp0, 84);
        check("tie1_fn", fn0, 0);
        check("tie1_fvec", fev0, 64);

        mode = 4;
        sweep(-1, -1, d0, d2, nd0, nd2, bc0, bc2);
        check("lat0_delayed_nonzero", err0 != 0, 1);
        check("lat2_again_err", err2, 0);

        mode = 2;
        sweep(100, -1, d0, d2, nd0, nd2, bc0, bc2);
        check("midstart_ndone", nd0, 1);
        check("midstart_done_at", d0, 512);
        check("midstart_fp", fp0, 84);
        check("midstart_ndone_lat2", nd2, 1);

        mode = 1;
        sweep(-1, 200, d0, d2, nd0, nd2, bc0, bc2);
        check("abort_ndone", nd0, 0);
        check("abort_ndone_lat2", nd2, 0);
        check("abort_err", err0, 0);
        check("abort_vec", {c0, b0, a0}, 0);
        sweep(-1, -1, d0, d2, nd0, nd2, bc0, bc2);
        check("rerun_ndone", nd0, 1);
        check("rerun_err", err0, 428);
        check("rerun_fn", fn0, 428);

        mode = 3;
        sweep(-1, -1, d0, d2, nd0, nd2, bc0, bc2);
        check("inv_err", err0, 512);
        check("inv_fp", fp0, 84);
        check("inv_fn", fn0, 428);
        check("inv_fvec", fev0, 0);
        check("inv_fvalid", fv0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
